// File: rtl/div_pkg.sv
// div_pkg: controller state encodings and div32 handshake constants
package div_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ABORT} state_t;
  localparam int DIV_LAT = 35;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the shared iterative divider with flush and watchdog abort
module div_ctrl
  import div_pkg::*;
#(
  parameter int MAX_CYCLES = 40,
  parameter int ABORT_LEN  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        timeout_o
);
  localparam int WD_MAX = (MAX_CYCLES > DIV_LAT + 1) ? MAX_CYCLES - 1 : DIV_LAT + 1;
  localparam int WW = $clog2(WD_MAX + 1);
  localparam int AW = $clog2(ABORT_LEN + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WD_MAX);
  localparam logic [AW-1:0] AB_LAST = AW'(ABORT_LEN - 1);
  state_t state;
  logic [WW-1:0] wdog;
  logic [AW-1:0] acnt;
  assign busy_o = state != S_IDLE;
  always_comb
    stallreq_o = (state == S_IDLE) ? ex_div_req_i & ~flush_i :
                 (state == S_BUSY) ? 1'b1 :
                 (state == S_DONE) ? ex_div_req_i : 1'b0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      wdog         <= '0;
      acnt         <= '0;
      div_start_o  <= 1'b0;
      div_annul_o  <= 1'b0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      hilo_we_o    <= 1'b0;
      hi_o         <= '0;
      lo_o         <= '0;
      timeout_o    <= 1'b0;
    end else begin
      hilo_we_o   <= 1'b0;
      timeout_o   <= 1'b0;
      div_annul_o <= 1'b0;
      case (state)
        S_IDLE: if (ex_div_req_i && !flush_i) begin
          div_signed_o <= ex_signed_i;
          div_op1_o    <= ex_op1_i;
          div_op2_o    <= ex_op2_i;
          div_start_o  <= DivStart;
          wdog         <= '0;
          state        <= S_BUSY;
        end
        S_BUSY: if (flush_i || (div_ready_i != DivResultReady && wdog == WD_LAST)) begin
          div_start_o <= DivStop;
          div_annul_o <= 1'b1;
          timeout_o   <= !flush_i;
          acnt        <= '0;
          state       <= S_ABORT;
        end else if (div_ready_i == DivResultReady) begin
          {hi_o, lo_o} <= div_result_i;
          hilo_we_o    <= 1'b1;
          div_start_o  <= DivStop;
          state        <= S_DONE;
        end else
          wdog <= wdog + 1'b1;
        S_DONE: state <= S_IDLE;
        S_ABORT: if (acnt == AB_LAST) state <= S_IDLE; else acnt <= acnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random divides against a behavioural divider and arithmetic model
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req, sgn, flush;
  logic [31:0] op1, op2;
  logic stallreq, div_start, div_annul, div_signed, hilo_we, busy, timeout;
  logic [31:0] div_op1, div_op2, hi, lo;
  logic [63:0] result;
  logic ready, stub_dead;
  int stub_cnt;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_div_req_i(req), .ex_signed_i(sgn), .ex_op1_i(op1), .ex_op2_i(op2),
    .flush_i(flush), .stallreq_o(stallreq),
    .div_start_o(div_start), .div_annul_o(div_annul), .div_signed_o(div_signed),
    .div_op1_o(div_op1), .div_op2_o(div_op2),
    .div_result_i(result), .div_ready_i(ready),
    .hilo_we_o(hilo_we), .hi_o(hi), .lo_o(lo),
    .busy_o(busy), .timeout_o(timeout)
  );

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // behavioural divider: ready after 35 start cycles (3 for a zero divisor), held until start drops
  always @(posedge clk or negedge rst)
    if (!rst) begin
      ready <= 1'b0; stub_cnt <= 0; result <= '0;
    end else if (div_annul || !div_start) begin
      ready <= 1'b0; stub_cnt <= 0;
    end else begin
      stub_cnt <= stub_cnt + 1;
      if (!stub_dead && stub_cnt + 1 == (div_op2 == 0 ? 3 : 35)) begin
        ready <= 1'b1;
        result <= ref_div(div_signed, div_op1, div_op2);
      end
    end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int extra, input string tag);
    int cyc = 0;
    int stalls = 0;
    int lat;
    logic got = 1'b0;
    lat = (b == 0 ? 3 : 35) + 2 + extra;
    sgn = s; op1 = a; op2 = b; req = 1'b1;
    if (extra != 0) begin
      #1 chk({tag, " start gap"}, div_start, 0);
    end
    while (!got && cyc < 100) begin
      #1 if (stallreq) stalls++;
      @(negedge clk);
      cyc++;
      if (cyc == 1 + extra) chk({tag, " ops"}, {div_start, div_signed, div_op1, div_op2}, {1'b1, s, a, b});
      got = hilo_we;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " stall"}, stalls, lat);
    chk({tag, " hilo"}, {hi, lo}, {eh, el});
  endtask

  task automatic finish_div(input string tag);
    req = 1'b0;
    #1 chk({tag, " done stall"}, stallreq, 0);
    @(negedge clk);
    chk({tag, " after"}, {hilo_we, busy, ready, stub_cnt != 0}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic [63:0] e;
    logic s, seen, we;
    int cyc;
    req = 0; sgn = 0; op1 = 0; op2 = 0; flush = 0; stub_dead = 0;
    #12;
    chk("reset ctl", {div_start, div_annul, stallreq, hilo_we, timeout, busy, div_signed}, 0);
    chk("reset data", {hi, lo, div_op1}, 0);
    chk("reset op2", div_op2, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0, "divu 100/7");
    finish_div("divu 100/7");
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, "div -7/2");
    finish_div("div -7/2");
    run_div(1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 0, "divu 5/0");
    finish_div("divu 5/0");
    run_div(1'b0, 32'd20, 32'd3, 32'd2, 32'd6, 0, "b2b 20/3");
    run_div(1'b0, 32'd21, 32'd4, 32'd1, 32'd5, 1, "b2b 21/4");
    finish_div("b2b 21/4");
    // flush in the middle of a divide
    sgn = 0; op1 = 32'd1000; op2 = 32'd7; req = 1'b1;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; req = 1'b0;
    #1 chk("flush annul", {div_annul, stallreq, hilo_we, busy, div_start}, 5'b10010);
    @(negedge clk);
    req = 1'b1; op1 = 32'd9; op2 = 32'd3;
    #1 chk("abort ignores req", {div_annul, stallreq, div_start, hilo_we}, 0);
    @(negedge clk);
    chk("abort hold", {busy, div_start, hilo_we}, 3'b100);
    req = 1'b0;
    @(negedge clk);
    chk("abort exit", {busy, hilo_we, ready, stub_cnt != 0}, 0);
    run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0, "after flush 9/3");
    finish_div("after flush 9/3");
    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(16, 30);
      if (b == 0) b = 32'd1;
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      e = ref_div(s, a, b);
      run_div(s, a, b, e[63:32], e[31:0], 0, "random");
      finish_div("random");
    end
    // never-ready divider drives the watchdog
    stub_dead = 1'b1;
    sgn = 0; op1 = $urandom; op2 = 32'd3; req = 1'b1;
    cyc = 0; seen = 1'b0; we = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      seen = timeout;
      if (hilo_we) we = 1'b1;
    end
    chk("timeout cycle", cyc, 41);
    chk("timeout pulse", {timeout, div_annul, div_start, we}, 4'b1100);
    req = 1'b0;
    @(negedge clk);
    chk("timeout one cycle", {timeout, div_annul, busy}, 3'b001);
    repeat (2) @(negedge clk);
    chk("timeout idle", {busy, hilo_we}, 0);
    stub_dead = 1'b0;
    // asynchronous reset in the middle of a divide
    sgn = 0; op1 = 32'd50; op2 = 32'd5; req = 1'b1;
    repeat (6) @(negedge clk);
    #1 rst = 1'b0;
    #1 chk("mid reset", {busy, div_start, hilo_we, div_op1}, 0);
    req = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    run_div(1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 0, "post reset 50/5");
    finish_div("post reset 50/5");
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
